// File: rtl/escalonador_poli_pkg.sv
// Shared types and defaults for the polynomial-evaluator scheduler.
// Imported by the interface, the arbiter and the top level.
package escalonador_pkg;

  typedef enum logic [1:0] {
    LIVRE,
    DISPARA,
    ESPERA,
    ENTREGA
  } estado_t;

  localparam int N_REQ_DEF   = 4;
  localparam int W_DEF       = 16;
  localparam int TIMEOUT_DEF = 64;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/escalonador_poli_if.sv
// Requester and evaluator signals of the scheduler.
// The slave side is the scheduler itself; the master side is its environment.
interface escalonador_poli_if
  import escalonador_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] x_in;
  logic [N_REQ*W-1:0] a_in;
  logic [N_REQ*W-1:0] b_in;
  logic [N_REQ*W-1:0] c_in;
  logic [N_REQ-1:0]   ack;
  logic [W-1:0]       res_out;
  logic               erro;
  logic               ocupado;

  logic               ev_inicio;
  logic [W-1:0]       ev_X;
  logic [W-1:0]       ev_A;
  logic [W-1:0]       ev_B;
  logic [W-1:0]       ev_C;
  logic               ev_pronto;
  logic               ev_done;
  logic [W-1:0]       ev_res;

  modport master (
    output req, x_in, a_in, b_in, c_in,
    output ev_pronto, ev_done, ev_res,
    input  ack, res_out, erro, ocupado,
    input  ev_inicio, ev_X, ev_A, ev_B, ev_C
  );

  modport slave (
    input  req, x_in, a_in, b_in, c_in,
    input  ev_pronto, ev_done, ev_res,
    output ack, res_out, erro, ocupado,
    output ev_inicio, ev_X, ev_A, ev_B, ev_C
  );

endinterface

// File: rtl/escalonador_poli_arbitro_rr.sv
// Combinational cyclic priority picker: first set req at or after ptr.
// Shared by the schedulers that front a single resource.
module arbitro_rr
  import escalonador_pkg::*;
#(
  parameter int N = N_REQ_DEF
) (
  input  logic [N-1:0]         req,
  input  logic [idx_w(N)-1:0]  ptr,
  output logic                 valid,
  output logic [idx_w(N)-1:0]  idx
);

  localparam int IW = idx_w(N);

  logic [IW-1:0] j;

  // Scan from the farthest slot back to ptr so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/escalonador_poli.sv
// Round-robin front end sharing one polynomial evaluator.
// Grants, fires a start pulse, waits with a watchdog, returns the result.
module escalonador_poli
  import escalonador_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic               ck,
  input logic               rst,
  escalonador_poli_if.slave bus
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  estado_t state;
  estado_t state_nx;

  logic [IW-1:0] ptr;
  logic [IW-1:0] id;
  logic [IW-1:0] gnt_idx;
  logic          gnt_ok;
  logic [CW-1:0] cnt;

  logic grant;
  logic fim_ok;
  logic fim_to;

  logic [N_REQ-1:0] ack;
  logic [W-1:0]     res;
  logic             erro;
  logic             ocupado;
  logic             inicio;
  logic [W-1:0]     op_x;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [W-1:0]     op_c;

  logic [W-1:0] xs [N_REQ];
  logic [W-1:0] as [N_REQ];
  logic [W-1:0] bs [N_REQ];
  logic [W-1:0] cs [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_op
    assign xs[i] = bus.x_in[i*W +: W];
    assign as[i] = bus.a_in[i*W +: W];
    assign bs[i] = bus.b_in[i*W +: W];
    assign cs[i] = bus.c_in[i*W +: W];
  end

  arbitro_rr #(
    .N (N_REQ)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (gnt_ok),
    .idx   (gnt_idx)
  );

  // Next state; done beats the watchdog when both land together.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    fim_ok   = 1'b0;
    fim_to   = 1'b0;
    unique case (state)
      LIVRE: begin
        if (gnt_ok && bus.ev_pronto) begin
          grant    = 1'b1;
          state_nx = DISPARA;
        end
      end
      DISPARA: state_nx = ESPERA;
      ESPERA: begin
        if (bus.ev_done) begin
          fim_ok   = 1'b1;
          state_nx = ENTREGA;
        end else if (cnt == CNT_LAST) begin
          fim_to   = 1'b1;
          state_nx = ENTREGA;
        end
      end
      ENTREGA: state_nx = LIVRE;
      default: state_nx = LIVRE;
    endcase
  end

  // State register.
  always_ff @(posedge ck) begin
    if (rst) state <= LIVRE;
    else     state <= state_nx;
  end

  // Operand, watchdog, pointer and registered output updates.
  always_ff @(posedge ck) begin
    if (rst) begin
      ptr     <= '0;
      id      <= '0;
      cnt     <= '0;
      ack     <= '0;
      res     <= '0;
      erro    <= 1'b0;
      ocupado <= 1'b0;
      inicio  <= 1'b0;
      op_x    <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_c    <= '0;
    end else begin
      inicio  <= grant;
      ocupado <= (state_nx != LIVRE);
      ack     <= '0;
      res     <= '0;
      erro    <= 1'b0;
      if (grant) begin
        id   <= gnt_idx;
        op_x <= xs[gnt_idx];
        op_a <= as[gnt_idx];
        op_b <= bs[gnt_idx];
        op_c <= cs[gnt_idx];
      end
      if (state == DISPARA)     cnt <= '0;
      else if (state == ESPERA) cnt <= cnt + 1'b1;
      if (fim_ok || fim_to) begin
        ack  <= N_REQ'(1) << id;
        res  <= fim_ok ? bus.ev_res : '0;
        erro <= fim_to;
      end
      if (state == ENTREGA) begin
        ptr <= (id == IW'(N_REQ - 1)) ? '0 : id + 1'b1;
      end
    end
  end

  assign bus.ack       = ack;
  assign bus.res_out   = res;
  assign bus.erro      = erro;
  assign bus.ocupado   = ocupado;
  assign bus.ev_inicio = inicio;
  assign bus.ev_X      = op_x;
  assign bus.ev_A      = op_a;
  assign bus.ev_B      = op_b;
  assign bus.ev_C      = op_c;

endmodule

// File: tb/tb_escalonador_poli.sv
// Directed bench for escalonador_poli with a stub evaluator.
// Expected results are hand-computed constants per vector.
module tb_escalonador_poli;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 8;

  logic ck = 1'b0;
  logic rst;

  int vecs = 0;
  int errs = 0;

  logic [W-1:0] ox [N];
  logic [W-1:0] oa [N];
  logic [W-1:0] ob [N];
  logic [W-1:0] oc [N];

  escalonador_poli_if #(.N_REQ(N), .W(W)) bus ();

  escalonador_poli #(
    .N_REQ   (N),
    .W       (W),
    .TIMEOUT (TO)
  ) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  task automatic load_ops;
    for (int i = 0; i < N; i++) begin
      bus.x_in[i*W +: W] = ox[i];
      bus.a_in[i*W +: W] = oa[i];
      bus.b_in[i*W +: W] = ob[i];
      bus.c_in[i*W +: W] = oc[i];
    end
  endtask

  // Stub evaluator: A*X^2 + B*X + C on the latched operands, W bits.
  function automatic logic [W-1:0] poly();
    logic [W-1:0] r;
    r = bus.ev_A * bus.ev_X * bus.ev_X + bus.ev_B * bus.ev_X + bus.ev_C;
    return r;
  endfunction

  // One job: grant at the next edge, then done after lat ESPERA cycles
  // (or never, for the watchdog), then the ack cycle and an idle cycle.
  task automatic job(input string tag, input int id, input int lat,
                     input bit done, input logic [W-1:0] res,
                     input logic [N-1:0] req_after);
    logic [N-1:0] one;
    one = N'(1) << id;
    tick;
    chk({tag, "_inicio"}, 32'(bus.ev_inicio), 1);
    chk({tag, "_ocup"}, 32'(bus.ocupado), 1);
    chk({tag, "_x"}, 32'(bus.ev_X), 32'(ox[id]));
    chk({tag, "_c"}, 32'(bus.ev_C), 32'(oc[id]));
    tick;
    chk({tag, "_inicio_1cyc"}, 32'(bus.ev_inicio), 0);
    if (done) begin
      repeat (lat) tick;
      bus.ev_res  = poly();
      bus.ev_done = 1'b1;
      chk({tag, "_early"}, 32'(bus.ack), 0);
      tick;
      bus.ev_done = 1'b0;
      bus.ev_res  = '0;
    end else begin
      repeat (TO - 1) tick;
      chk({tag, "_early"}, 32'(bus.ack), 0);
      tick;
    end
    chk({tag, "_ack"}, 32'(bus.ack), 32'(one));
    chk({tag, "_res"}, 32'(bus.res_out), 32'(res));
    chk({tag, "_erro"}, 32'(bus.erro), done ? 0 : 1);
    bus.req = req_after;
    tick;
    chk({tag, "_ack_off"}, 32'(bus.ack), 0);
    chk({tag, "_res_off"}, 32'(bus.res_out), 0);
    chk({tag, "_livre"}, 32'(bus.ocupado), 0);
  endtask

  initial begin
    ox[0] = 16'd1;  oa[0] = 16'd1; ob[0] = 16'd1; oc[0] = 16'd1;
    ox[1] = 16'd2;  oa[1] = 16'd3; ob[1] = 16'd4; oc[1] = 16'd5;
    ox[2] = 16'd3;  oa[2] = 16'd2; ob[2] = 16'd1; oc[2] = 16'd0;
    ox[3] = 16'd10; oa[3] = 16'd1; ob[3] = 16'd2; oc[3] = 16'd3;
    rst           = 1'b1;
    bus.req       = '0;
    bus.ev_pronto = 1'b1;
    bus.ev_done   = 1'b0;
    bus.ev_res    = '0;
    load_ops();
    repeat (3) tick;
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_res", 32'(bus.res_out), 0);
    chk("rst_erro", 32'(bus.erro), 0);
    chk("rst_ocup", 32'(bus.ocupado), 0);
    chk("rst_inicio", 32'(bus.ev_inicio), 0);
    chk("rst_evx", 32'(bus.ev_X), 0);
    rst = 1'b0;
    tick;

    // Fairness with every requester held high from ptr 0.
    bus.req = 4'b1111;
    job("fair0", 0, 1, 1'b1, 16'd3, 4'b1111);
    job("fair1", 1, 2, 1'b1, 16'd25, 4'b1111);
    job("fair2", 2, 0, 1'b1, 16'd21, 4'b1111);
    job("fair3", 3, 3, 1'b1, 16'd123, 4'b1111);
    job("fair4", 0, 1, 1'b1, 16'd3, 4'b0000);

    // Single job, done five cycles after the start pulse.
    bus.req = 4'b0010;
    job("single", 1, 4, 1'b1, 16'd25, 4'b0000);

    // Evaluator busy: nothing may start until ev_pronto rises.
    bus.ev_pronto = 1'b0;
    bus.req       = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("busy_inicio", 32'(bus.ev_inicio), 0);
      chk("busy_ocup", 32'(bus.ocupado), 0);
    end
    bus.ev_pronto = 1'b1;
    job("busy", 2, 1, 1'b1, 16'd21, 4'b0000);

    // Watchdog expiry, then a normal minimum-latency job.
    bus.req = 4'b1000;
    job("tmo", 3, 0, 1'b0, 16'd0, 4'b0000);
    bus.req = 4'b0001;
    job("post_tmo", 0, 0, 1'b1, 16'd3, 4'b0000);

    // Done lands in the watchdog's last cycle.
    bus.req = 4'b0100;
    job("coll", 2, TO - 1, 1'b1, 16'd21, 4'b0000);

    // Spurious done while idle.
    bus.ev_done = 1'b1;
    bus.ev_res  = 16'hBEEF;
    tick;
    bus.ev_done = 1'b0;
    bus.ev_res  = '0;
    chk("spur_ack", 32'(bus.ack), 0);
    chk("spur_ocup", 32'(bus.ocupado), 0);
    chk("spur_res", 32'(bus.res_out), 0);
    tick;
    chk("spur_ack2", 32'(bus.ack), 0);

    // Reset in ESPERA; ptr was 3, so a 1001 request must pick 0 after.
    bus.req = 4'b0010;
    tick;
    chk("mid_inicio", 32'(bus.ev_inicio), 1);
    chk("mid_x", 32'(bus.ev_X), 2);
    tick;
    tick;
    rst     = 1'b1;
    bus.req = '0;
    tick;
    chk("mid_ack", 32'(bus.ack), 0);
    chk("mid_ocup", 32'(bus.ocupado), 0);
    chk("mid_inicio0", 32'(bus.ev_inicio), 0);
    chk("mid_evx", 32'(bus.ev_X), 0);
    chk("mid_res", 32'(bus.res_out), 0);
    chk("mid_erro", 32'(bus.erro), 0);
    rst = 1'b0;
    tick;
    chk("mid_ack2", 32'(bus.ack), 0);
    bus.req = 4'b1001;
    job("rst_p0", 0, 2, 1'b1, 16'd3, 4'b1000);
    job("rst_p3", 3, 2, 1'b1, 16'd123, 4'b0000);

    // Result wraps at W bits: 300^2 = 90000 -> 24464.
    ox[0] = 16'd300; oa[0] = 16'd1; ob[0] = 16'd0; oc[0] = 16'd0;
    load_ops();
    bus.req = 4'b0001;
    job("wrap", 0, 3, 1'b1, 16'd24464, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/escalonador_poli.md
# escalonador_poli

Round-robin scheduler that shares one polynomial evaluator (start/ready/done handshake, 16-bit operands X, A, B, C, 16-bit result) among N_REQ independent requesters. It sits between the requesters and the evaluator. Per job it arbitrates, latches the winner's operands, issues a one-cycle start, waits for done with a watchdog, and returns the result to the winner with a one-cycle acknowledge. The evaluator is not modified; this block only drives its start and operand inputs.

## Interface
- N_REQ, 4: number of requesters (2..8)
- W, 16: operand/result width
- TIMEOUT, 64: max cycles in ESPERA before abort (≥2)

- ck  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  level request per requester; held until its ack
- x_in, a_in, b_in, c_in  in  N_REQ*W  packed operands; requester i uses slice [i*W +: W]; stable while req[i] high
- ack  out  N_REQ  one-cycle pulse to the served requester
- res_out  out  W  result; valid only in the ack cycle, 0 otherwise
- erro  out  1  one-cycle pulse coincident with ack when the job timed out
- ocupado  out  1  high in every state except LIVRE
- ev_inicio  out  1  one-cycle start pulse to evaluator
- ev_X, ev_A, ev_B, ev_C  out  W  registered operands, held from grant until the next grant
- ev_pronto  in  1  evaluator idle and able to accept a start
- ev_done  in  1  evaluator result-valid pulse
- ev_res  in  W  evaluator result, sampled when ev_done=1

## Operation
- States: LIVRE → DISPARA → ESPERA → ENTREGA → LIVRE.
- LIVRE: if (|req) && ev_pronto, grant the first i with req[i]=1, searching cyclically from pointer ptr. Latch the four operand slices into ev_*, latch id=i, then go to DISPARA. Otherwise stay.
- DISPARA: ev_inicio=1 for exactly this cycle; clear the watchdog counter; go to ESPERA.
- ESPERA: counter increments each cycle.
  - ev_done=1: latch ev_res into the result register, erro flag=0, go to ENTREGA.
  - Otherwise, if the counter equals TIMEOUT-1: result register=0, erro flag=1, go to ENTREGA.
  - ev_done and timeout in the same cycle: done wins.
- ENTREGA: ack[id]=1, res_out=result register, erro=erro flag; ptr ← (id+1) mod N_REQ; go to LIVRE.
- ev_done outside ESPERA is ignored and has no effect on state or outputs.
- Requesters deassert req[i] in the cycle after ack. A req[i] still high in LIVRE is treated as a new request and arbitrated normally.
- req changes outside LIVRE have no effect until return to LIVRE.
- Counter width is clog2(TIMEOUT). Result is passed through unmodified (W bits, no saturation).
- Reset values: state LIVRE, ptr 0, id 0, ev_* 0, ev_inicio 0, ack 0, res_out 0, erro 0, ocupado 0, counter 0.
- rst mid-job aborts with no ack. The evaluator shares rst, so no drain is needed.

## Timing
- Grant edge t (LIVRE, req and ev_pronto sampled high) → ev_inicio high during cycle t+1 → ESPERA from cycle t+2.
- ev_done sampled high in cycle d → ack/res_out during cycle d+1. Minimum req-to-ack latency is 3 cycles (done in t+2, ack in t+3).
- Timeout: ack with erro during cycle t+2+TIMEOUT.
- Back-to-back: one idle LIVRE cycle between an ack and the next grant edge.
- Every output is registered; no combinational path from req or ev_* inputs to any output.

## Structure
- Package escalonador_pkg: state enum (LIVRE, DISPARA, ESPERA, ENTREGA), default W and N_REQ constants.
- Sub-module arbitro_rr: combinational cyclic priority picker (req, ptr → grant valid, grant index). Reused by other shared-resource schedulers.
- Top level contains the FSM, operand/result registers, watchdog counter and ptr.

## Test plan
- Single job: req[1]=1, X=2, A=3, B=4, C=5; bench evaluator computes A·X²+B·X+C after 5 cycles. Required: ev_inicio 1 cycle; ack=4'b0010 with res_out=25 exactly 1 cycle after ev_done; erro=0.
- Fairness: req=4'b1111 held, ptr=0. Required: ack order 0,1,2,3,0; no requester served twice before the others.
- Busy evaluator: ev_pronto=0 for 10 cycles with req[2]=1. Required: no ev_inicio and state LIVRE throughout; grant on the first cycle ev_pronto=1.
- Timeout: TIMEOUT=8, evaluator never asserts done. Required: ack[id] and erro high in the same cycle at t+10, res_out=0; the next request is served normally.
- Done/timeout collision and spurious done: ev_done in the timeout cycle → erro=0, res_out=ev_res. ev_done pulsed in LIVRE → no ack, state unchanged.
- Reset mid-job: rst in ESPERA. Required: next cycle all outputs 0, ptr 0, no ack; a fresh req[3] is served first.
